// File: rtl/fib_seq_engine_pkg.sv
// Shared types for the Fibonacci engine: ALU opcodes and FSM states.
// Imported by the ALU and the engine top.
package fib_pkg;

  localparam int FIB_WIDTH = 10;
  localparam int FIB_NW    = 6;

  typedef enum logic [2:0] {
    OP_PASS_X = 3'b000,
    OP_PASS_Y = 3'b001,
    OP_ONE    = 3'b010,
    OP_DEC    = 3'b011,
    OP_ADD    = 3'b100
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/fib_seq_engine_if.sv
// Start/busy/done handshake bundle for fib_seq_engine.
// master: start,n out / busy,done,result,overflow in; slave: reverse.
interface fib_seq_engine_if #(
  parameter int WIDTH = 10,
  parameter int NW    = 6
);
  logic             start;
  logic [NW-1:0]    n;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;

  modport master (
    output start, n,
    input  busy, done, result, overflow
  );

  modport slave (
    input  start, n,
    output busy, done, result, overflow
  );
endinterface

// File: rtl/fib_seq_engine_alu.sv
// fib_alu: combinational function-select ALU (pass/one/dec/add).
// Ports: fnselect[2:0], x, y -> z, cout (cout valid for OP_ADD only).
module fib_alu
  import fib_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic [2:0]       fnselect,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic             cout
);

  always_comb begin
    z    = '0;
    cout = 1'b0;
    case (fnselect)
      OP_PASS_X: z = x;
      OP_PASS_Y: z = y;
      OP_ONE:    z = WIDTH'(1);
      OP_DEC:    z = x - WIDTH'(1);
      OP_ADD:    {cout, z} = {1'b0, x} + {1'b0, y};
      default: begin
        z    = '0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fib_seq_engine.sv
// Sequential Fibonacci engine: F(n) with overflow, start/busy/done handshake.
// Ports: clk, rst_n (async low), bus (slave). Option: FIB_SAT_EN saturates result.
module fib_seq_engine
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int NW    = FIB_NW
) (
  input logic              clk,
  input logic              rst_n,
  fib_seq_engine_if.slave  bus
);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [NW-1:0]    cnt_q;
  logic             a_ovf_q, b_ovf_q;
  logic             busy_q, done_q, ovf_q;

  logic             step;
  logic [2:0]       op;
  logic [WIDTH-1:0] alu_z;
  logic             alu_c;

  assign step = (state_q == ST_RUN) && (cnt_q != '0);
  assign op   = step ? OP_ADD : OP_PASS_X;

  fib_alu #(.WIDTH(WIDTH)) u_alu (
    .fnselect (op),
    .x        (a_q),
    .y        (b_q),
    .z        (alu_z),
    .cout     (alu_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      a_ovf_q <= 1'b0;
      b_ovf_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= '0;
            b_q     <= WIDTH'(1);
            cnt_q   <= bus.n;
            a_ovf_q <= 1'b0;
            b_ovf_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (step) begin
            a_q     <= b_q;
            b_q     <= alu_z;
            cnt_q   <= cnt_q - NW'(1);
            // a's flag follows a; b's flag absorbs any wrap so far
            a_ovf_q <= b_ovf_q;
            b_ovf_q <= b_ovf_q | a_ovf_q | alu_c;
          end else begin
`ifdef FIB_SAT_EN
            res_q   <= a_ovf_q ? '1 : alu_z;
`else
            res_q   <= alu_z;
`endif
            ovf_q   <= a_ovf_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = res_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_fib_seq_engine.sv
// Self-checking bench for fib_seq_engine (WIDTH=10, NW=6).
// Transaction-level model plus directed literal checks and random stimulus.
module tb_fib_seq_engine;

  localparam int W  = 10;
  localparam int NW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  fib_seq_engine_if #(.WIDTH(W), .NW(NW)) bus ();

  fib_seq_engine #(.WIDTH(W), .NW(NW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic longint unsigned fib_true(input int k);
    longint unsigned a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic logic exp_ovf(input int k);
    return fib_true(k) > longint'((1 << W) - 1);
  endfunction

  function automatic logic [W-1:0] exp_res(input int k);
    longint unsigned f;
    f = fib_true(k);
`ifdef FIB_SAT_EN
    if (exp_ovf(k)) return '1;
`endif
    return f[W-1:0];
  endfunction

  task automatic check(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Transaction model: accept when idle, done n+1 edges later.
  logic           m_busy, m_done, m_ovf, m_pov;
  logic [W-1:0]   m_res, m_pres;
  int             m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_ovf  <= 1'b0;
      m_pres <= '0;
      m_pov  <= 1'b0;
      m_left <= 0;
    end else if (!m_busy && bus.start) begin
      m_busy <= 1'b1;
      m_done <= 1'b0;
      m_left <= int'(bus.n) + 1;
      m_pres <= exp_res(int'(bus.n));
      m_pov  <= exp_ovf(int'(bus.n));
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_res  <= m_pres;
        m_ovf  <= m_pov;
      end
      m_left <= m_left - 1;
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", bus.busy, m_busy);
      check("done", bus.done, m_done);
      check("result", bus.result, m_res);
      check("overflow", bus.overflow, m_ovf);
    end
  end

  // Assumes start is already set for the next edge; clears it after.
  task automatic wait_done(input string nm, input int exp_edges,
                           input longint er, input longint eo);
    int e;
    bit seen;
    e = 0;
    seen = 0;
    while (!seen && e < 200) begin
      @(negedge clk);
      e++;
      bus.start = 1'b0;
      if (bus.done) seen = 1;
    end
    check({nm, "_seen"}, seen, 1);
    check({nm, "_edges"}, e, exp_edges);
    check({nm, "_res"}, bus.result, er);
    check({nm, "_ovf"}, bus.overflow, eo);
  endtask

  task automatic go(input int k);
    @(negedge clk);
    bus.start = 1'b1;
    bus.n = NW'(k);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.n = '0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_ovf", bus.overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    check("model_f10", fib_true(10), 55);
    check("model_f16", fib_true(16), 987);
    check("model_f17", fib_true(17), 1597);

    go(0);
    @(negedge clk);
    bus.start = 1'b0;
    check("n0_busy1", bus.busy, 1);
    @(negedge clk);
    check("n0_done", bus.done, 1);
    check("n0_busy0", bus.busy, 0);
    check("n0_res", bus.result, 0);

    go(1);
    wait_done("n1", 3, 1, 0);
    go(10);
    wait_done("n10", 12, 55, 0);
    go(16);
    wait_done("n16", 18, 987, 0);
    go(17);
`ifdef FIB_SAT_EN
    wait_done("n17", 19, 1023, 1);
`else
    wait_done("n17", 19, 573, 1);
`endif

    go(10);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.n = NW'(3);
    @(negedge clk);
    bus.start = 1'b0;
    begin
      int e;
      e = 0;
      while (!bus.done && e < 100) begin
        @(negedge clk);
        e++;
      end
    end
    check("ignore_res", bus.result, 55);
    check("ignore_done", bus.done, 1);
    bus.start = 1'b1;
    bus.n = NW'(5);
    wait_done("b2b", 7, 5, 0);

    go(20);
    repeat (5) @(negedge clk);
    bus.start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_result", bus.result, 0);
    check("arst_ovf", bus.overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("arst_nodone", bus.done, 0);
    go(5);
    wait_done("after_rst", 7, 5, 0);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.n = NW'($urandom_range(0, 40));
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (70) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
